// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word requests to
// instruction memory, buffers responses in a small FIFO and hands them to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        ImReq,
    output logic [31:0] ImAddr,
    input  logic        ImAck,
    input  logic        ImRValid,
    input  logic [31:0] ImRData,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        InstValid,
    input  logic        InstReady,
    output logic [31:0] Instruction,
    output logic [31:0] InstPC,
    output logic [31:0] InstPCPlus4
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 2;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;

    logic          pop;
    logic          transfer;
    logic          push;
    logic [CW-1:0] in_use;
    logic [CW-1:0] outstanding_next;
    logic [31:0]   redirect_target;

    // Handshakes: a transfer happens on a cycle where valid and the matching
    // ready/ack are both high; valid never waits on ready, and the payload is
    // held stable while valid is high and the transfer has not happened.
    assign pop      = InstValid & InstReady;
    assign transfer = ImReq & ImAck;

    // Every FIFO slot is reserved at request time, so a response always has room.
    assign in_use = count + outstanding - CW'(pop);
    assign ImReq  = !Reset && (in_use < CW'(DEPTH));
    assign ImAddr = fetch_pc;

    assign push             = ImRValid && (drop == '0) && !Redirect;
    assign outstanding_next = outstanding + CW'(transfer) - CW'(ImRValid);
    assign redirect_target  = {RedirectPC[31:2], 2'b00};

    assign InstValid   = (count != '0);
    assign Instruction = fifo_instr[rd_ptr];
    assign InstPC      = fifo_pc[rd_ptr];
    assign InstPCPlus4 = InstPC + 32'd4;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else begin
            outstanding <= outstanding_next;
            if (Redirect) begin
                // Everything still in flight after this edge, including a request
                // accepted this cycle, belongs to the abandoned stream.
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                fetch_pc <= redirect_target;
                resp_pc  <= redirect_target;
                drop     <= outstanding_next;
            end else begin
                if (transfer) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (ImRValid && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
                if (push) begin
                    fifo_instr[wr_ptr] <= ImRData;
                    fifo_pc[wr_ptr]    <= resp_pc;
                    wr_ptr             <= wr_ptr + PW'(1);
                    resp_pc            <= resp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order variable-latency memory model, expected
// instruction-stream scoreboard, directed scenarios followed by random traffic.
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        ImReq;
    logic [31:0] ImAddr;
    logic        ImAck = 1'b0;
    logic        ImRValid = 1'b0;
    logic [31:0] ImRData = '0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = '0;
    logic        InstValid;
    logic        InstReady = 1'b0;
    logic [31:0] Instruction;
    logic [31:0] InstPC;
    logic [31:0] InstPCPlus4;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset),
        .ImReq(ImReq), .ImAddr(ImAddr), .ImAck(ImAck),
        .ImRValid(ImRValid), .ImRData(ImRData),
        .Redirect(Redirect), .RedirectPC(RedirectPC),
        .InstValid(InstValid), .InstReady(InstReady),
        .Instruction(Instruction), .InstPC(InstPC), .InstPCPlus4(InstPCPlus4)
    );

    // ---------------- clock / watchdog ----------------
    always #5 Clk = ~Clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    // ---------------- shared state ----------------
    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];          // {pc, instruction} the decode side must see, in order
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    int cyc = 0;
    int last_due = 0;
    int ack_p = 100, ready_p = 100, redir_pm = 0, lat_min = 1, lat_max = 1;
    logic        force_redir = 1'b0;
    logic [31:0] force_target = '0;
    logic [31:0] model_fetch_pc = RESET_PC;
    int accept_cnt = 0;
    int pop_cnt = 0;
    logic        s_imreq, s_valid;
    logic [31:0] s_imaddr, s_pc, s_pc4;
    logic [63:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'hC0DE_0000) * 32'h9E37_79B1 + 32'h1357_9BDF;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge Clk) begin
        if (!Reset && InstValid && InstReady) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %h expected no instruction", InstPC);
            end else begin
                mon_e = exp_q.pop_front();
                check("inst_pc", InstPC, mon_e[63:32]);
                check("instruction", Instruction, mon_e[31:0]);
                check("inst_pc_plus4", InstPCPlus4, mon_e[63:32] + 32'd4);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        Reset = 1'b1;
        Redirect = 1'b0; ImAck = 1'b0; ImRValid = 1'b0; InstReady = 1'b0;
        RedirectPC = '0; ImRData = '0;
        mem_addr_q.delete();
        mem_due_q.delete();
        exp_q.delete();
        model_fetch_pc = RESET_PC;
        @(negedge Clk); #1;
        check("rst_im_req", 32'(ImReq), 32'd0);
        check("rst_im_addr", ImAddr, RESET_PC);
        check("rst_inst_valid", 32'(InstValid), 32'd0);
        check("rst_instruction", Instruction, 32'd0);
        check("rst_inst_pc", InstPC, 32'd0);
        check("rst_inst_pc_plus4", InstPCPlus4, 32'd4);
        @(posedge Clk); #1;
        Reset = 1'b0;
        cyc++;
        last_due = cyc;
    endtask

    // One clock cycle: drive inputs, sample at mid-cycle, update the model.
    task automatic step();
        int lat;
        int due;
        ImAck     = ($urandom_range(99) < ack_p);
        InstReady = ($urandom_range(99) < ready_p);
        if (force_redir) begin
            Redirect = 1'b1; RedirectPC = force_target; force_redir = 1'b0;
        end else if ($urandom_range(999) < redir_pm) begin
            Redirect = 1'b1; RedirectPC = $urandom;
        end else begin
            Redirect = 1'b0; RedirectPC = $urandom;
        end
        if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
            ImRValid = 1'b1;
            ImRData  = mem_word(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end else begin
            ImRValid = 1'b0;
            ImRData  = $urandom;
        end
        @(negedge Clk); #1;
        s_imreq = ImReq; s_imaddr = ImAddr; s_valid = InstValid; s_pc = InstPC; s_pc4 = InstPCPlus4;
        if (ImReq && ImAck) begin
            check("im_addr", ImAddr, model_fetch_pc);
            accept_cnt++;
            lat = int'($urandom_range(lat_max, lat_min));
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_addr_q.push_back(model_fetch_pc);
            mem_due_q.push_back(due);
            if (!Redirect) exp_q.push_back({model_fetch_pc, mem_word(model_fetch_pc)});
            model_fetch_pc = model_fetch_pc + 32'd4;
        end
        if (Redirect) begin
            exp_q.delete();
            model_fetch_pc = {RedirectPC[31:2], 2'b00};
        end
        @(posedge Clk); #1;
        cyc++;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int pops_before;
        logic [31:0] held;

        // startup: L=1, ack and ready held high
        do_reset();
        ack_p = 100; ready_p = 100; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("startup_addr", s_imaddr, 32'(i * 4));
            check("startup_valid", 32'(s_valid), (i == 2) ? 32'd1 : 32'd0);
        end
        check("startup_first_pc", s_pc, 32'd0);
        pops_before = pop_cnt;
        repeat (10) step();
        check("throughput_pops", 32'(pop_cnt - pops_before), 32'd10);

        // decode stall from empty: only DEPTH requests may go out
        do_reset();
        ready_p = 0; accept_cnt = 0;
        repeat (10) step();
        check("stall_accepts", 32'(accept_cnt), 32'(DEPTH));
        check("stall_im_req", 32'(s_imreq), 32'd0);
        check("stall_head_pc", s_pc, 32'd0);
        check("stall_valid", 32'(s_valid), 32'd1);
        ready_p = 100;
        repeat (6) step();

        // memory back-pressure: address must hold
        ack_p = 0;
        step();
        held = s_imaddr;
        repeat (4) begin
            step();
            check("ack_hold_addr", s_imaddr, held);
        end
        ack_p = 100;
        repeat (6) step();

        // redirect with two slow requests in flight
        do_reset();
        lat_min = 3; lat_max = 3;
        repeat (2) step();
        force_redir = 1'b1; force_target = 32'h0000_0103;
        step();
        step();
        check("redir_next_addr", s_imaddr, 32'h0000_0100);
        for (int k = 0; k < 20 && !s_valid; k++) step();
        check("redir_seen", 32'(s_valid), 32'd1);
        check("redir_pc", s_pc, 32'h0000_0100);
        check("redir_pc_plus4", s_pc4, 32'h0000_0104);
        repeat (6) step();

        // redirect colliding with transfer, response and pop in one cycle
        lat_min = 1; lat_max = 1;
        repeat (6) step();
        force_redir = 1'b1; force_target = 32'h0000_0200;
        step();
        check("collide_req", 32'(s_imreq), 32'd1);
        check("collide_valid", 32'(s_valid), 32'd1);
        repeat (10) step();

        // asynchronous reset mid-stream
        do_reset();
        ready_p = 0; lat_min = 2; lat_max = 2;
        repeat (3) step();
        check("pre_reset_valid", 32'(InstValid), 32'd1);
        #1;
        Reset = 1'b1;
        #1;
        check("async_rst_im_req", 32'(ImReq), 32'd0);
        check("async_rst_valid", 32'(InstValid), 32'd0);
        check("async_rst_instruction", Instruction, 32'd0);
        do_reset();
        ready_p = 100; lat_min = 1; lat_max = 1;
        step();
        check("restart_addr", s_imaddr, RESET_PC);
        force_redir = 1'b1; force_target = 32'hFFFF_FFF8;
        step();
        repeat (12) step();

        // random traffic
        ack_p = 70; ready_p = 70; lat_min = 1; lat_max = 4; redir_pm = 30;
        repeat (800) step();

        // drain
        ack_p = 0; ready_p = 100; redir_pm = 0;
        for (int k = 0; k < 60 && (mem_due_q.size() > 0 || s_valid); k++) step();
        repeat (3) step();
        check("drain_exp_empty", 32'(exp_q.size()), 32'd0);
        check("drain_valid", 32'(s_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
